// File: rtl/l2_noc1_msg_assembler_if.sv
// Bundles the NoC1 flit input and the assembled-message output of the L2 input stage.
// Both sides use valid/ready: a transfer happens on a rising clk edge when valid && ready;
// a source holds valid and its data stable until that transfer, and a sink may change ready freely.
interface l2_noc1_msg_assembler_if #(
  parameter int MAX_PAYLOAD = 2,
  parameter int DEPTH       = 2
);
  logic                          noc1_valid_in;
  logic [63:0]                   noc1_data_in;
  logic                          noc1_ready_in;
  logic                          msg_valid;
  logic                          msg_ready;
  logic [63:0]                   msg_header;
  logic [64*MAX_PAYLOAD-1:0]     msg_payload;
  logic [7:0]                    msg_len;
  logic [7:0]                    msg_type;
  logic                          len_err;
  logic [$clog2(DEPTH+1)-1:0]    occupancy;

  modport slave (
    input  noc1_valid_in, noc1_data_in, msg_ready,
    output noc1_ready_in, msg_valid, msg_header, msg_payload, msg_len, msg_type,
           len_err, occupancy
  );

  modport master (
    output noc1_valid_in, noc1_data_in, msg_ready,
    input  noc1_ready_in, msg_valid, msg_header, msg_payload, msg_len, msg_type,
           len_err, occupancy
  );
endinterface

// File: rtl/l2_noc1_msg_assembler.sv
// Groups NoC1 header+payload flits into whole messages and queues them in a small FIFO,
// so the consumer only ever pops complete requests.
module l2_noc1_msg_assembler #(
  parameter int MAX_PAYLOAD = 2,
  parameter int DEPTH       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  l2_noc1_msg_assembler_if.slave        bus,
  output logic                          o_dbg_state
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_PAYLOAD = 1'b1} state_t;

  state_t                    r_state, w_state_next;
  logic [63:0]               r_hdr;
  logic [63:0]               r_pay [MAX_PAYLOAD];
  logic [CNT_W-1:0]          r_cnt;
  logic [7:0]                r_rem;
  logic [7:0]                r_len;
  logic                      r_len_err;

  logic [63:0]               r_fifo_hdr [DEPTH];
  logic [64*MAX_PAYLOAD-1:0] r_fifo_pay [DEPTH];
  logic [7:0]                r_fifo_len [DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]          r_count;

  logic                      w_ready, w_valid, w_acc, w_pop;
  logic                      w_push, w_hdr_accept, w_pay_accept;
  logic [7:0]                w_flit_len, w_len_min;
  logic                      w_len_big;
  logic [63:0]               w_push_hdr;
  logic [64*MAX_PAYLOAD-1:0] w_push_pay;
  logic [7:0]                w_push_len;

  // Ready depends only on the registered count, so a pop never re-opens the input in the same cycle.
  assign w_ready    = (r_count != OCC_W'(DEPTH));
  assign w_valid    = (r_count != '0);
  assign w_acc      = bus.noc1_valid_in && w_ready;
  assign w_pop      = w_valid && bus.msg_ready;
  assign w_flit_len = bus.noc1_data_in[29:22];
  assign w_len_big  = (w_flit_len > 8'(MAX_PAYLOAD));
  assign w_len_min  = w_len_big ? 8'(MAX_PAYLOAD) : w_flit_len;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_hdr_accept = 1'b0;
    w_pay_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          w_hdr_accept = 1'b1;
          if (w_flit_len == 8'd0) w_push = 1'b1;
          else                    w_state_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (w_acc) begin
          w_pay_accept = 1'b1;
          if (r_rem == 8'd1) begin
            w_push       = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A zero-length header is pushed directly from the bus; otherwise the last flit is merged in.
  always_comb begin
    w_push_hdr = (r_state == ST_IDLE) ? bus.noc1_data_in : r_hdr;
    w_push_len = (r_state == ST_IDLE) ? 8'd0 : r_len;
    w_push_pay = '0;
    if (r_state == ST_PAYLOAD) begin
      for (int k = 0; k < MAX_PAYLOAD; k++) begin
        if (r_cnt == CNT_W'(k)) w_push_pay[64*k +: 64] = bus.noc1_data_in;
        else                    w_push_pay[64*k +: 64] = r_pay[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdr     <= '0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_len     <= '0;
      r_len_err <= 1'b0;
      for (int k = 0; k < MAX_PAYLOAD; k++) r_pay[k] <= '0;
    end else begin
      r_len_err <= w_hdr_accept && w_len_big;
      if (w_hdr_accept) begin
        r_hdr <= bus.noc1_data_in;
        r_cnt <= '0;
        r_rem <= w_flit_len;
        r_len <= w_len_min;
        for (int k = 0; k < MAX_PAYLOAD; k++) r_pay[k] <= '0;
      end
      if (w_pay_accept) begin
        r_rem <= r_rem - 8'd1;
        // Flits past MAX_PAYLOAD are consumed but not stored.
        if (r_cnt < CNT_W'(MAX_PAYLOAD)) begin
          r_cnt <= r_cnt + CNT_W'(1);
          for (int k = 0; k < MAX_PAYLOAD; k++) begin
            if (r_cnt == CNT_W'(k)) r_pay[k] <= bus.noc1_data_in;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_hdr[i] <= '0;
        r_fifo_pay[i] <= '0;
        r_fifo_len[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_hdr[r_wr_ptr] <= w_push_hdr;
        r_fifo_pay[r_wr_ptr] <= w_push_pay;
        r_fifo_len[r_wr_ptr] <= w_push_len;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields read as zero while the FIFO is empty.
  assign bus.noc1_ready_in = w_ready;
  assign bus.msg_valid     = w_valid;
  assign bus.msg_header    = w_valid ? r_fifo_hdr[r_rd_ptr] : '0;
  assign bus.msg_payload   = w_valid ? r_fifo_pay[r_rd_ptr] : '0;
  assign bus.msg_len       = w_valid ? r_fifo_len[r_rd_ptr] : '0;
  assign bus.msg_type      = bus.msg_header[21:14];
  assign bus.len_err       = r_len_err;
  assign bus.occupancy     = r_count;
  assign o_dbg_state       = (r_state == ST_PAYLOAD);

endmodule

// File: tb/tb_l2_noc1_msg_assembler.sv
// Directed bench for the NoC1 message assembler: framing, zero-length, back-pressure/wrap,
// oversize headers, gapped input and mid-message reset.
module tb_l2_noc1_msg_assembler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;
  int   n_tests = 0;
  int   n_fail  = 0;

  l2_noc1_msg_assembler_if #(.MAX_PAYLOAD(2), .DEPTH(2)) bus ();

  l2_noc1_msg_assembler #(.MAX_PAYLOAD(2), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [7:0] len, input logic [7:0] typ,
                                         input logic [15:0] tag);
    return {tag, 18'h0, len, typ, 14'h0};
  endfunction

  // Holds the flit on the bus until it is taken at a clock edge; valid is left high.
  task automatic send_flit(input logic [63:0] d);
    int n;
    n = 0;
    bus.noc1_valid_in = 1'b1;
    bus.noc1_data_in  = d;
    while (!bus.noc1_ready_in && n < 50) begin
      step();
      n++;
    end
    check("flit_accept_timeout", 128'(n < 50), 128'(1));
    step();
  endtask

  task automatic idle_in();
    bus.noc1_valid_in = 1'b0;
    bus.noc1_data_in  = '0;
  endtask

  logic [63:0] h;

  initial begin
    bus.noc1_valid_in = 1'b0;
    bus.noc1_data_in  = '0;
    bus.msg_ready     = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("rst_ready",   128'(bus.noc1_ready_in), 128'(1));
    check("rst_valid",   128'(bus.msg_valid),     128'(0));
    check("rst_header",  128'(bus.msg_header),    128'(0));
    check("rst_payload", 128'(bus.msg_payload),   128'(0));
    check("rst_len",     128'(bus.msg_len),       128'(0));
    check("rst_type",    128'(bus.msg_type),      128'(0));
    check("rst_len_err", 128'(bus.len_err),       128'(0));
    check("rst_occ",     128'(bus.occupancy),     128'(0));
    check("rst_state",   128'(dbg_state),         128'(0));
    rst = 1'b0;
    step();

    // Basic message, back-to-back flits, consumer always ready
    bus.msg_ready = 1'b1;
    h = mk_hdr(8'd2, 8'h0D, 16'hABCD);
    send_flit(h);
    check("b2b_state_after_hdr", 128'(dbg_state), 128'(1));
    send_flit(64'hA5);
    check("b2b_partial_invisible", 128'(bus.msg_valid), 128'(0));
    send_flit(64'h5A);
    idle_in();
    check("b2b_valid",   128'(bus.msg_valid),   128'(1));
    check("b2b_header",  128'(bus.msg_header),  128'(h));
    check("b2b_len",     128'(bus.msg_len),     128'(2));
    check("b2b_type",    128'(bus.msg_type),    128'(8'h0D));
    check("b2b_payload", bus.msg_payload,       128'h0000_0000_0000_005A_0000_0000_0000_00A5);
    check("b2b_occ1",    128'(bus.occupancy),   128'(1));
    check("b2b_state_idle", 128'(dbg_state),    128'(0));
    step();
    check("b2b_occ0",    128'(bus.occupancy),   128'(0));
    check("b2b_valid0",  128'(bus.msg_valid),   128'(0));

    // Zero-length header is a complete message on its own
    bus.msg_ready = 1'b0;
    h = mk_hdr(8'd0, 8'h22, 16'h0F0F);
    send_flit(h);
    idle_in();
    check("z_valid",   128'(bus.msg_valid),   128'(1));
    check("z_header",  128'(bus.msg_header),  128'(h));
    check("z_len",     128'(bus.msg_len),     128'(0));
    check("z_payload", bus.msg_payload,       128'(0));
    check("z_state",   128'(dbg_state),       128'(0));
    step();
    check("z_stable_occ", 128'(bus.occupancy), 128'(1));
    check("z_stable_hdr", 128'(bus.msg_header), 128'(h));
    bus.msg_ready = 1'b1;
    step();
    bus.msg_ready = 1'b0;
    check("z_pop_occ", 128'(bus.occupancy), 128'(0));

    // Fill FIFO, hold a third header, pop once, check order and pointer wrap
    send_flit(mk_hdr(8'd1, 8'h01, 16'h000A));
    send_flit(64'h11);
    send_flit(mk_hdr(8'd0, 8'h02, 16'h000B));
    idle_in();
    check("full_occ",   128'(bus.occupancy),     128'(2));
    check("full_ready", 128'(bus.noc1_ready_in), 128'(0));
    check("full_head",  128'(bus.msg_header),    128'(mk_hdr(8'd1, 8'h01, 16'h000A)));
    check("full_head_pay", bus.msg_payload,      128'h11);
    bus.noc1_valid_in = 1'b1;
    bus.noc1_data_in  = mk_hdr(8'd1, 8'h03, 16'h000C);
    step();
    step();
    check("held_ready", 128'(bus.noc1_ready_in), 128'(0));
    check("held_state", 128'(dbg_state),         128'(0));
    check("held_occ",   128'(bus.occupancy),     128'(2));
    bus.msg_ready = 1'b1;
    step();
    bus.msg_ready = 1'b0;
    check("pop1_occ",   128'(bus.occupancy),     128'(1));
    check("pop1_ready", 128'(bus.noc1_ready_in), 128'(1));
    check("pop1_state_no_accept", 128'(dbg_state), 128'(0));
    check("pop1_head",  128'(bus.msg_header),    128'(mk_hdr(8'd0, 8'h02, 16'h000B)));
    step();
    check("c_hdr_accepted", 128'(dbg_state), 128'(1));
    send_flit(64'h33);
    idle_in();
    check("c_occ2",  128'(bus.occupancy),  128'(2));
    check("c_head_b_type", 128'(bus.msg_type), 128'(8'h02));
    bus.msg_ready = 1'b1;
    step();
    bus.msg_ready = 1'b0;
    check("wrap_head",   128'(bus.msg_header), 128'(mk_hdr(8'd1, 8'h03, 16'h000C)));
    check("wrap_len",    128'(bus.msg_len),    128'(1));
    check("wrap_pay",    bus.msg_payload,      128'h33);
    check("wrap_occ",    128'(bus.occupancy),  128'(1));
    bus.msg_ready = 1'b1;
    step();
    bus.msg_ready = 1'b0;
    check("wrap_empty", 128'(bus.occupancy), 128'(0));

    // Oversize header: extra flits dropped, length error pulses once
    send_flit(mk_hdr(8'd4, 8'h07, 16'h4444));
    check("ovr_len_err_pulse", 128'(bus.len_err), 128'(1));
    send_flit(64'hF0);
    check("ovr_len_err_clear", 128'(bus.len_err), 128'(0));
    send_flit(64'hF1);
    send_flit(64'hF2);
    check("ovr_partial_invisible", 128'(bus.msg_valid), 128'(0));
    send_flit(64'hF3);
    check("ovr_occ",  128'(bus.occupancy), 128'(1));
    check("ovr_len",  128'(bus.msg_len),   128'(2));
    check("ovr_type", 128'(bus.msg_type),  128'(8'h07));
    check("ovr_pay",  bus.msg_payload,     128'h0000_0000_0000_00F1_0000_0000_0000_00F0);
    send_flit(mk_hdr(8'd1, 8'h02, 16'h5555));
    check("next_len_err", 128'(bus.len_err), 128'(0));
    send_flit(64'h77);
    idle_in();
    check("next_occ", 128'(bus.occupancy), 128'(2));
    bus.msg_ready = 1'b1;
    step();
    bus.msg_ready = 1'b0;
    check("next_type", 128'(bus.msg_type), 128'(8'h02));
    check("next_len",  128'(bus.msg_len),  128'(1));
    check("next_pay",  bus.msg_payload,    128'h77);
    bus.msg_ready = 1'b1;
    step();
    bus.msg_ready = 1'b0;

    // Gapped input produces the same message as back-to-back
    h = mk_hdr(8'd2, 8'h0D, 16'hABCD);
    send_flit(h);
    idle_in();
    step();
    check("gap_hold_state", 128'(dbg_state), 128'(1));
    send_flit(64'hA5);
    idle_in();
    step();
    check("gap_partial_invisible", 128'(bus.msg_valid), 128'(0));
    send_flit(64'h5A);
    idle_in();
    check("gap_valid",   128'(bus.msg_valid),  128'(1));
    check("gap_header",  128'(bus.msg_header), 128'(h));
    check("gap_len",     128'(bus.msg_len),    128'(2));
    check("gap_payload", bus.msg_payload,      128'h0000_0000_0000_005A_0000_0000_0000_00A5);
    check("gap_occ",     128'(bus.occupancy),  128'(1));
    bus.msg_ready = 1'b1;
    step();
    bus.msg_ready = 1'b0;

    // Reset mid-message discards the partial message and queued entries
    send_flit(mk_hdr(8'd0, 8'h09, 16'h9999));
    send_flit(mk_hdr(8'd2, 8'h0A, 16'hAAAA));
    send_flit(64'hCC);
    idle_in();
    check("pre_rst_occ", 128'(bus.occupancy), 128'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_valid", 128'(bus.msg_valid),     128'(0));
    check("mrst_occ",   128'(bus.occupancy),     128'(0));
    check("mrst_state", 128'(dbg_state),         128'(0));
    check("mrst_ready", 128'(bus.noc1_ready_in), 128'(1));
    h = mk_hdr(8'd2, 8'h0E, 16'h1234);
    send_flit(h);
    send_flit(64'hD1);
    send_flit(64'hD2);
    idle_in();
    check("post_rst_header", 128'(bus.msg_header), 128'(h));
    check("post_rst_len",    128'(bus.msg_len),    128'(2));
    check("post_rst_pay",    bus.msg_payload,      128'h0000_0000_0000_00D2_0000_0000_0000_00D1);
    check("post_rst_occ",    128'(bus.occupancy),  128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
